mux_n_choice_pipe: RTL and testbench
====================================

MUX_N_CHOICE_PIPE -- requirements
Module: mux_n_choice_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24: data width of each choice and of the output.
REQ-002 The block SHALL have parameter NUM_CHOICES, default 4 (legal 2..16): number of selectable inputs.
REQ-003 The block SHALL have derived localparam SEL_W = $clog2(NUM_CHOICES), minimum 1.
REQ-004 The block SHALL have port clk, input, 1: single clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port choices, input, NUM_CHOICES*WIDTH: flattened bus, with choice k at bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port select, input, SEL_W: index of the choice to forward.
REQ-008 The block SHALL have port in_valid, input, 1: choices/select are valid this cycle.
REQ-009 The block SHALL have port in_ready, output, 1: the block accepts the input this cycle.
REQ-010 The block SHALL have port out_data, output, WIDTH: registered selected choice.
REQ-011 The block SHALL have port out_sel, output, SEL_W: select value captured with out_data.
REQ-012 The block SHALL have port out_valid, output, 1: out_data/out_sel are valid.
REQ-013 The block SHALL have port out_ready, input, 1: the consumer accepts the output this cycle.
REQ-014 The block SHALL have port sel_err, output, 1: sticky flag, set when an accepted select is >= NUM_CHOICES.
REQ-015 The block SHALL have port err_clr, input, 1: synchronous clear of sel_err.

Function
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-017 On an input transfer, the output stage SHALL capture choices[select] and select; latency from acceptance to out_valid SHALL be exactly 1 cycle.
REQ-018 If select >= NUM_CHOICES on an accepted transfer, out_data SHALL be 0, out_sel SHALL equal select, and sel_err SHALL be 1 from the next cycle.
REQ-019 While out_valid=1 and out_ready=0, out_data, out_sel and out_valid SHALL hold stable.
REQ-020 Without the skid buffer, in_ready SHALL equal (~out_valid | out_ready), a combinational path.
REQ-021 A simultaneous input and output transfer SHALL replace the output register with no bubble, so throughput is 1 item per cycle.
REQ-022 If err_clr and a new out-of-range accept occur in the same cycle, the set SHALL take priority and sel_err SHALL remain 1.
REQ-023 When in_valid=0, no state other than the out_valid drain on an output transfer SHALL change; data is never silently overwritten.

Reset
REQ-024 While rst_n=0, out_valid, sel_err, out_data and out_sel SHALL be 0 and any skid entry SHALL be empty, asynchronously.
REQ-025 Reset deassertion SHALL be used synchronously to clk; in_ready SHALL be 1 on the first cycle after release.
REQ-026 Reset asserted mid-transfer SHALL drop all held data; it SHALL NOT be replayed after reset.

Configuration
REQ-027 With macro MUX_N_CHOICE_SKID_EN defined, a 1-entry skid register SHALL be added, and in_ready SHALL be a pure register output (in_ready = ~skid_full).
REQ-028 With MUX_N_CHOICE_SKID_EN defined, an input accepted while the output is stalled SHALL go to the skid entry, and it SHALL move to the output on the next output transfer; ordering SHALL be preserved, and throughput SHALL still be 1 per cycle.
REQ-029 Without MUX_N_CHOICE_SKID_EN, the behaviour SHALL be exactly REQ-020, with no skid storage.

Structure
REQ-030 Shared package mux_pkg SHALL hold MUX_DEF_WIDTH=24, MUX_DEF_CHOICES=4, and a function computing SEL_W.
REQ-031 One sub-module, pipe_reg_stage (WIDTH+SEL_W payload, valid/ready, optional skid), SHALL hold all handshake state; selection logic SHALL stay in the top level.

Verification
REQ-032 Reset release, then NUM_CHOICES=4, choices={0xDDDDDD,0xCCCCCC,0xBBBBBB,0xAAAAAA}, select=2, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=0xCCCCCC, out_sel=2.
REQ-033 Streaming select 0,1,2,3 on consecutive cycles with out_ready=1 -> outputs 0xAAAAAA, 0xBBBBBB, 0xCCCCCC, 0xDDDDDD on 4 consecutive cycles, no bubbles.
REQ-034 out_ready=0 for 5 cycles with input select=1 then select=3 offered -> out_data holds 0xBBBBBB; without the macro in_ready=0; with the macro one extra item is accepted; after release, 0xDDDDDD follows with none lost.
REQ-035 NUM_CHOICES=3, select=3 accepted -> out_data=0, sel_err=1; err_clr pulse -> sel_err=0; err_clr coincident with another select=3 -> sel_err stays 1.
REQ-036 rst_n pulled low while out_valid=1 and stalled -> out_valid=0 immediately (asynchronously); after release, no stale item is presented.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared defaults and the select-width helper for the N-choice pipelined multiplexer.
package mux_pkg;

    localparam int MUX_DEF_WIDTH   = 24;
    localparam int MUX_DEF_CHOICES = 4;

    // A 2-choice mux still needs one select bit, so the width never drops below 1.
    function automatic int sel_w_calc(input int num_choices);
        return (num_choices <= 2) ? 1 : $clog2(num_choices);
    endfunction

endpackage

// File: rtl/mux_n_choice_pipe_stage.sv
// Valid/ready register stage holding all handshake state; optional 1-entry skid
// register enabled by MUX_N_CHOICE_SKID_EN.
module pipe_reg_stage #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

`ifdef MUX_N_CHOICE_SKID_EN
    logic                 skid_full;
    logic [PAYLOAD_W-1:0] skid_data;

    // in_ready comes straight from a flop, cutting the ready path back to the producer.
    assign in_ready = ~skid_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_full <= 1'b0;
            skid_data <= '0;
        end else if (!out_valid || out_ready) begin
            // Output slot frees up: the older skid item always goes first.
            if (skid_full) begin
                out_data  <= skid_data;
                out_valid <= 1'b1;
                skid_full <= 1'b0;
            end else if (in_valid) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_valid && !skid_full) begin
            skid_data <= in_data;
            skid_full <= 1'b1;
        end
    end
`else
    assign in_ready = ~out_valid | out_ready;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/mux_n_choice_pipe.sv
// N-choice multiplexer with a registered valid/ready output stage and sticky
// out-of-range select flag. Define MUX_N_CHOICE_SKID_EN to add a skid entry.
module mux_n_choice_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH       = MUX_DEF_WIDTH,
    parameter  int NUM_CHOICES = MUX_DEF_CHOICES,
    localparam int SEL_W       = sel_w_calc(NUM_CHOICES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CHOICES*WIDTH-1:0] choices,
    input  logic [SEL_W-1:0]             select,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [SEL_W-1:0]             out_sel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         sel_err,
    input  logic                         err_clr
);

    logic [WIDTH-1:0]       sel_data;
    logic                   sel_oor;
    logic                   in_xfer;
    logic [SEL_W+WIDTH-1:0] stage_out;

    assign sel_oor = int'(select) >= NUM_CHOICES;
    assign in_xfer = in_valid & in_ready;

    // NOTE: sel_data is defaulted before the loop so no select value infers a latch.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CHOICES; k++) begin
            if (select == SEL_W'(k)) begin
                sel_data = choices[k*WIDTH +: WIDTH];
            end
        end
    end

    pipe_reg_stage #(
        .PAYLOAD_W (SEL_W + WIDTH)
    ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({select, sel_data}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (stage_out)
    );

    assign out_sel  = stage_out[SEL_W+WIDTH-1:WIDTH];
    assign out_data = stage_out[WIDTH-1:0];

    // A new out-of-range accept wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (in_xfer && sel_oor) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_n_choice_pipe.sv
// Self-checking bench: queue-based model for a 4-choice instance plus directed
// literal checks, including a 3-choice instance for out-of-range selects.
module tb_mux_n_choice_pipe;

`ifdef MUX_N_CHOICE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4-choice instance
    logic [95:0] choices4;
    logic [1:0]  select4;
    logic        in_valid4, in_ready4, out_valid4, out_ready4, sel_err4, err_clr4;
    logic [23:0] out_data4;
    logic [1:0]  out_sel4;

    // 3-choice instance
    logic [71:0] choices3;
    logic [1:0]  select3;
    logic        in_valid3, in_ready3, out_valid3, out_ready3, sel_err3, err_clr3;
    logic [23:0] out_data3;
    logic [1:0]  out_sel3;

    mux_n_choice_pipe #(.WIDTH(24), .NUM_CHOICES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .choices(choices4), .select(select4),
        .in_valid(in_valid4), .in_ready(in_ready4), .out_data(out_data4),
        .out_sel(out_sel4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sel_err(sel_err4), .err_clr(err_clr4)
    );

    mux_n_choice_pipe #(.WIDTH(24), .NUM_CHOICES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .choices(choices3), .select(select3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready3),
        .sel_err(sel_err3), .err_clr(err_clr3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model of the 4-choice instance: items in flight held as a FIFO of depth CAP.
    typedef struct packed {
        logic [1:0]  sel;
        logic [23:0] data;
    } item_t;

    item_t q[$];
    bit    m_err = 1'b0;

    function automatic bit model_ready();
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || (out_ready4 === 1'b1);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            bit    acc;
            bit    pop;
            item_t it;
            acc = (in_valid4 === 1'b1) && model_ready();
            pop = (q.size() > 0) && (out_ready4 === 1'b1);
            if (pop) void'(q.pop_front());
            if (acc) begin
                it.sel  = select4;
                it.data = (int'(select4) < 4) ? choices4[int'(select4)*24 +: 24] : 24'h0;
                q.push_back(it);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("m_out_valid", 64'(out_valid4), 64'(q.size() > 0));
            check("m_in_ready", 64'(in_ready4), 64'(model_ready()));
            check("m_sel_err", 64'(sel_err4), 64'(m_err));
            if (q.size() > 0) begin
                check("m_out_data", 64'(out_data4), 64'(q[0].data));
                check("m_out_sel", 64'(out_sel4), 64'(q[0].sel));
            end
        end
    end

    logic [23:0] stream_exp [4];
    int          accepted;

    initial begin
        stream_exp[0] = 24'hAAAAAA;
        stream_exp[1] = 24'hBBBBBB;
        stream_exp[2] = 24'hCCCCCC;
        stream_exp[3] = 24'hDDDDDD;

        choices4 = {24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA};
        choices3 = {24'h333333, 24'h222222, 24'h111111};
        select4 = 2'd0; in_valid4 = 1'b0; out_ready4 = 1'b0; err_clr4 = 1'b0;
        select3 = 2'd0; in_valid3 = 1'b0; out_ready3 = 1'b0; err_clr3 = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_out_valid", 64'(out_valid4), 64'd0);
        check("rst_out_data", 64'(out_data4), 64'd0);
        check("rst_out_sel", 64'(out_sel4), 64'd0);
        check("rst_sel_err", 64'(sel_err4), 64'd0);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", 64'(in_ready4), 64'd1);

        // Single transfer, select 2
        step();
        in_valid4 = 1'b1; select4 = 2'd2; out_ready4 = 1'b1;
        step();
        check("first_out_valid", 64'(out_valid4), 64'd1);
        check("first_out_data", 64'(out_data4), 64'hCCCCCC);
        check("first_out_sel", 64'(out_sel4), 64'd2);

        // Back-to-back stream 0..3
        for (int i = 0; i < 4; i++) begin
            select4 = 2'(i);
            step();
            check("stream_valid", 64'(out_valid4), 64'd1);
            check("stream_data", 64'(out_data4), 64'(stream_exp[i]));
            check("stream_sel", 64'(out_sel4), 64'(i));
        end
        in_valid4 = 1'b0;
        step();
        check("drain_valid", 64'(out_valid4), 64'd0);

        // Stall with select 1 presented, then select 3 offered for 5 cycles
        in_valid4 = 1'b1; select4 = 2'd1;
        step();
        check("stall_first_data", 64'(out_data4), 64'hBBBBBB);
        out_ready4 = 1'b0; select4 = 2'd3;
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_in_ready", 64'(in_ready4), (CAP == 2 && i == 0) ? 64'd1 : 64'd0);
            if (in_ready4 === 1'b1) accepted++;
            step();
            check("stall_hold_valid", 64'(out_valid4), 64'd1);
            check("stall_hold_data", 64'(out_data4), 64'hBBBBBB);
            check("stall_hold_sel", 64'(out_sel4), 64'd1);
        end
        check("stall_accepted", 64'(accepted), 64'(CAP - 1));
        out_ready4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        check("release_data", 64'(out_data4), 64'hDDDDDD);
        check("release_sel", 64'(out_sel4), 64'd3);
        step();
        check("release_drain", 64'(out_valid4), 64'd0);

        // Out-of-range select on the 3-choice instance
        in_valid3 = 1'b1; select3 = 2'd2; out_ready3 = 1'b1;
        step();
        check("c3_in_range_data", 64'(out_data3), 64'h333333);
        check("c3_in_range_err", 64'(sel_err3), 64'd0);
        select3 = 2'd3;
        step();
        in_valid3 = 1'b0;
        check("c3_oor_data", 64'(out_data3), 64'd0);
        check("c3_oor_sel", 64'(out_sel3), 64'd3);
        check("c3_oor_valid", 64'(out_valid3), 64'd1);
        check("c3_oor_err", 64'(sel_err3), 64'd1);
        step();
        check("c3_err_sticky", 64'(sel_err3), 64'd1);
        err_clr3 = 1'b1;
        step();
        check("c3_err_cleared", 64'(sel_err3), 64'd0);
        in_valid3 = 1'b1; select3 = 2'd3;
        step();
        in_valid3 = 1'b0; err_clr3 = 1'b0;
        check("c3_set_beats_clr", 64'(sel_err3), 64'd1);

        // Asynchronous reset while stalled
        out_ready4 = 1'b0; in_valid4 = 1'b1; select4 = 2'd0;
        step();
        in_valid4 = 1'b0;
        check("pre_rst_valid", 64'(out_valid4), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid4), 64'd0);
        check("async_rst_data", 64'(out_data4), 64'd0);
        check("async_rst_err3", 64'(sel_err3), 64'd0);
        step();
        rst_n = 1'b1;
        out_ready4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_replay_valid", 64'(out_valid4), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
